// File: rtl/if_fetch_unit_if.sv
// ROM-side and IF/ID-side bus of the instruction fetch unit.
// IF_ALIGN_CHECK_EN adds the registered misalignment flag.
interface if_fetch_unit_if;
    logic        rom_ce_o;
    logic [31:0] pc_o;
    logic [31:0] inst_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
`ifdef IF_ALIGN_CHECK_EN
    logic        id_misalign_o;
`endif

    modport master (
        output rom_ce_o, pc_o, id_pc_o, id_inst_o,
`ifdef IF_ALIGN_CHECK_EN
        output id_misalign_o,
`endif
        input  inst_i
    );

    modport slave (
        input  rom_ce_o, pc_o, id_pc_o, id_inst_o,
`ifdef IF_ALIGN_CHECK_EN
        input  id_misalign_o,
`endif
        output inst_i
    );
endinterface

// File: rtl/if_fetch_unit.sv
// MIPS IF stage: PC register, ROM enable and the IF/ID pipeline register.
// Optional IF_ALIGN_CHECK_EN flags misaligned fetches and NOPs them out.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             stall,
    input  logic                   branch_flag_i,
    input  logic [31:0]            branch_target_address_i,
    input  logic                   flush,
    input  logic [31:0]            new_pc,
    if_fetch_unit_if.master        bus
);
    logic        ce_q;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        misalign;
    logic        unused_stall;

    // Stall bits beyond ID belong to later stages.
    assign unused_stall = ^stall[5:3];

`ifdef IF_ALIGN_CHECK_EN
    logic id_mis_q, id_mis_d;
    assign misalign = (pc_q[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        pc_d = pc_q;
        if (flush)
            pc_d = new_pc;
        else if (!stall[0])
            pc_d = branch_flag_i ? branch_target_address_i : pc_q + 32'd4;
    end

    always_comb begin
        id_pc_d   = id_pc_q;
        id_inst_d = id_inst_q;
`ifdef IF_ALIGN_CHECK_EN
        id_mis_d  = id_mis_q;
`endif
        if (flush || (stall[1] && !stall[2])) begin
            id_pc_d   = 32'h0;
            id_inst_d = NOP_INST;
`ifdef IF_ALIGN_CHECK_EN
            id_mis_d  = 1'b0;
`endif
        end else if (!stall[1]) begin
            id_pc_d   = pc_q;
            id_inst_d = misalign ? NOP_INST : bus.inst_i;
`ifdef IF_ALIGN_CHECK_EN
            id_mis_d  = misalign;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ce_q      <= 1'b0;
            pc_q      <= RESET_PC;
            id_pc_q   <= 32'h0;
            id_inst_q <= 32'h0;
`ifdef IF_ALIGN_CHECK_EN
            id_mis_q  <= 1'b0;
`endif
        end else begin
            ce_q      <= 1'b1;
            // PC only starts moving once the ROM has been enabled for a cycle.
            pc_q      <= ce_q ? pc_d : RESET_PC;
            id_pc_q   <= id_pc_d;
            id_inst_q <= id_inst_d;
`ifdef IF_ALIGN_CHECK_EN
            id_mis_q  <= id_mis_d;
`endif
        end
    end

    assign bus.rom_ce_o  = ce_q;
    assign bus.pc_o      = pc_q;
    assign bus.id_pc_o   = id_pc_q;
    assign bus.id_inst_o = id_inst_q;
`ifdef IF_ALIGN_CHECK_EN
    assign bus.id_misalign_o = id_mis_q;
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed table-driven bench for if_fetch_unit with a combinational ROM model
// returning 32'hA000_0000 ^ address (zero while the ROM is disabled).
module tb_if_fetch_unit;
    localparam logic [31:0] NOP = 32'hFEED_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        br;
    logic [31:0] tgt;
    logic        flush;
    logic [31:0] new_pc;
    int          n_tests = 0;
    int          n_fail  = 0;

    if_fetch_unit_if bus ();

    if_fetch_unit #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .branch_flag_i           (br),
        .branch_target_address_i (tgt),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .bus                     (bus.master)
    );

    assign bus.inst_i = bus.rom_ce_o ? (32'hA000_0000 ^ bus.pc_o) : 32'h0;

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [5:0]  stall;
        logic        br;
        logic [31:0] tgt;
        logic        flush;
        logic [31:0] new_pc;
        logic        ce;
        logic [31:0] pc;
        logic [31:0] id_pc;
        logic [31:0] id_inst;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [5:0] s, input logic b, input logic [31:0] t,
                         input logic f, input logic [31:0] np);
        rst = r; stall = s; br = b; tgt = t; flush = f; new_pc = np;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input logic ce, input logic [31:0] pc,
                             input logic [31:0] idpc, input logic [31:0] idinst);
        chk({name, ".ce"},      {31'h0, bus.rom_ce_o}, {31'h0, ce});
        chk({name, ".pc"},      bus.pc_o,      pc);
        chk({name, ".id_pc"},   bus.id_pc_o,   idpc);
        chk({name, ".id_inst"}, bus.id_inst_o, idinst);
    endtask

    initial begin
        //            name        rst stall       br tgt           fl new_pc        ce pc            id_pc         id_inst
        vecs.push_back('{"rst0",    1, 6'b000000, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        32'h0});
        vecs.push_back('{"rst1",    1, 6'b000011, 1, 32'h80,       0, 32'h0,        0, 32'h0,        32'h0,        32'h0});
        vecs.push_back('{"rst2",    1, 6'b000000, 1, 32'h80,       1, 32'h500,      0, 32'h0,        32'h0,        32'h0});
        vecs.push_back('{"en",      0, 6'b000000, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0,        32'h0});
        vecs.push_back('{"seq4",    0, 6'b000000, 0, 32'h0,        0, 32'h0,        1, 32'h4,        32'h0,        32'hA000_0000});
        vecs.push_back('{"seq8",    0, 6'b000000, 0, 32'h0,        0, 32'h0,        1, 32'h8,        32'h4,        32'hA000_0004});
        vecs.push_back('{"seqC",    0, 6'b000000, 0, 32'h0,        0, 32'h0,        1, 32'hC,        32'h8,        32'hA000_0008});
        vecs.push_back('{"seq10",   0, 6'b000000, 0, 32'h0,        0, 32'h0,        1, 32'h10,       32'hC,        32'hA000_000C});
        vecs.push_back('{"br40",    0, 6'b000000, 1, 32'h40,       0, 32'h0,        1, 32'h40,       32'h10,       32'hA000_0010});
        vecs.push_back('{"tgt40",   0, 6'b000000, 0, 32'h0,        0, 32'h0,        1, 32'h44,       32'h40,       32'hA000_0040});
        vecs.push_back('{"br20",    0, 6'b000000, 1, 32'h20,       0, 32'h0,        1, 32'h20,       32'h44,       32'hA000_0044});
        vecs.push_back('{"bub1",    0, 6'b000011, 0, 32'h0,        0, 32'h0,        1, 32'h20,       32'h0,        NOP});
        vecs.push_back('{"bub2",    0, 6'b000011, 0, 32'h0,        0, 32'h0,        1, 32'h20,       32'h0,        NOP});
        vecs.push_back('{"resume",  0, 6'b000000, 0, 32'h0,        0, 32'h0,        1, 32'h24,       32'h20,       32'hA000_0020});
        vecs.push_back('{"hold1",   0, 6'b000111, 1, 32'h80,       0, 32'h0,        1, 32'h24,       32'h20,       32'hA000_0020});
        vecs.push_back('{"hold2",   0, 6'b000111, 0, 32'h0,        0, 32'h0,        1, 32'h24,       32'h20,       32'hA000_0020});
        vecs.push_back('{"unhold",  0, 6'b000000, 0, 32'h0,        0, 32'h0,        1, 32'h28,       32'h24,       32'hA000_0024});
        vecs.push_back('{"flush",   0, 6'b000011, 1, 32'h40,       1, 32'h100,      1, 32'h100,      32'h0,        NOP});
        vecs.push_back('{"post_fl", 0, 6'b000000, 0, 32'h0,        0, 32'h0,        1, 32'h104,      32'h100,      32'hA000_0100});
        vecs.push_back('{"brtop",   0, 6'b000000, 1, 32'hFFFF_FFFC,0, 32'h0,        1, 32'hFFFF_FFFC,32'h104,      32'hA000_0104});
        vecs.push_back('{"wrap",    0, 6'b000000, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'hFFFF_FFFC,32'h5FFF_FFFC});
        vecs.push_back('{"pcstall", 0, 6'b000001, 1, 32'h80,       0, 32'h0,        1, 32'h0,        32'h0,        32'hA000_0000});
        vecs.push_back('{"rst_mid", 1, 6'b000001, 1, 32'h80,       1, 32'h300,      0, 32'h0,        32'h0,        32'h0});
        vecs.push_back('{"reen",    0, 6'b000000, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0,        32'h0});
        vecs.push_back('{"idstall", 0, 6'b000100, 0, 32'h0,        0, 32'h0,        1, 32'h4,        32'h0,        32'hA000_0000});
        vecs.push_back('{"fl_hold", 0, 6'b000111, 0, 32'h0,        1, 32'h200,      1, 32'h200,      32'h0,        NOP});
        vecs.push_back('{"post_fh", 0, 6'b000000, 0, 32'h0,        0, 32'h0,        1, 32'h204,      32'h200,      32'hA000_0200});

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt, vecs[i].flush, vecs[i].new_pc);
            check_all(vecs[i].name, vecs[i].ce, vecs[i].pc, vecs[i].id_pc, vecs[i].id_inst);
        end

        // Long hold: pc=0x204, IF/ID holds 0x200 for five cycles, then resumes.
        for (int k = 0; k < 5; k++) begin
            drive(0, 6'b000111, 0, 32'h0, 0, 32'h0);
            check_all("longhold", 1'b1, 32'h204, 32'h200, 32'hA000_0200);
        end
        drive(0, 6'b000000, 0, 32'h0, 0, 32'h0);
        check_all("longrel", 1'b1, 32'h208, 32'h204, 32'hA000_0204);

`ifdef IF_ALIGN_CHECK_EN
        chk("mis_aligned", {31'h0, bus.id_misalign_o}, 32'h0);
        drive(0, 6'b000000, 1, 32'h42, 0, 32'h0);
        check_all("br42", 1'b1, 32'h42, 32'h208, 32'hA000_0208);
        drive(0, 6'b000000, 0, 32'h0, 0, 32'h0);
        check_all("mis_cap", 1'b1, 32'h46, 32'h42, NOP);
        chk("mis_flag", {31'h0, bus.id_misalign_o}, 32'h1);
        drive(0, 6'b000011, 0, 32'h0, 0, 32'h0);
        chk("mis_bubble", {31'h0, bus.id_misalign_o}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
